// File: rtl/noc_bus_bridge_pkg.sv
// Shared definitions for the NoC <-> bus bridge.
// Holds the default flit width and FIFO depth, the router flit type,
// and the outbound packet sequencer state encoding.
package HeMPS_defaults;

  localparam int TAM_FLIT  = 32;
  localparam int BUF_DEPTH = 4;

  // Router flit as used on the bridge ports when FLIT_W = TAM_FLIT.
  typedef logic [TAM_FLIT-1:0] regflit;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BACKOFF,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD,
    S_RELEASE
  } bridge_state_t;

endpackage

// File: rtl/noc_bus_bridge_fifo.sv
// bridge_fifo: synchronous FIFO with fall-through head (dout is the oldest
// entry whenever empty = 0). Push while full and pop while empty are ignored.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-low reset
//   push, din       write request and data
//   pop             read request (advances the head)
//   dout            current head entry
//   full, empty     occupancy flags
module bridge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_bus_bridge.sv
// noc_bus_bridge: joins a router local port to a shared bus.
// Router -> bus flits are buffered in an outbound FIFO and sent as packets
// (header, size, size payload flits) after winning bus arbitration.
// Bus -> router flits pass through an inbound FIFO.
// Ports:
//   clock, reset                      clock, synchronous active-low reset
//   rx, data_in, credit_o             router -> bridge flit handshake
//   tx, data_out, credit_i            bridge -> router flit handshake
//   rx_b, data_in_b, credit_o_b       bus -> bridge flit handshake
//   tx_b, data_out_b, credit_i_b      bridge -> bus flit handshake
//   tx_addr_b                         destination of the packet on the bus
//   request, grant, using_bus, ack    bus arbitration
module noc_bus_bridge
  import HeMPS_defaults::*;
#(
  parameter int FLIT_W      = TAM_FLIT,
  parameter int DEPTH       = BUF_DEPTH,
  parameter int REQ_TIMEOUT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic [FLIT_W-1:0] data_in,
  output logic              credit_o,
  output logic              tx,
  output logic [FLIT_W-1:0] data_out,
  input  logic              credit_i,
  input  logic              rx_b,
  input  logic [FLIT_W-1:0] data_in_b,
  output logic              credit_o_b,
  output logic              tx_b,
  output logic [FLIT_W-1:0] data_out_b,
  output logic [FLIT_W-1:0] tx_addr_b,
  input  logic              credit_i_b,
  output logic              request,
  input  logic              grant,
  output logic              using_bus,
  output logic              ack
);

  localparam int HW = FLIT_W / 2;

  bridge_state_t state, state_nxt;

  logic              out_full, out_empty, in_full, in_empty;
  logic [FLIT_W-1:0] out_head;
  logic              in_pkt, xfer;
  logic [HW-1:0]     pay_cnt;
  logic [31:0]       wait_cnt;

  bridge_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx),
    .din   (data_in),
    .pop   (xfer),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty)
  );

  bridge_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_b),
    .din   (data_in_b),
    .pop   (tx && credit_i),
    .dout  (data_out),
    .full  (in_full),
    .empty (in_empty)
  );

  assign credit_o   = !out_full;
  assign credit_o_b = !in_full;
  assign tx         = !in_empty;

  // Bus is held from HEADER through PAYLOAD even if the FIFO runs dry.
  assign in_pkt     = (state == S_HEADER) || (state == S_SIZE) || (state == S_PAYLOAD);
  assign using_bus  = in_pkt;
  assign tx_b       = in_pkt && !out_empty;
  assign data_out_b = out_head;
  assign xfer       = tx_b && credit_i_b;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      pay_cnt   <= '0;
      wait_cnt  <= '0;
      tx_addr_b <= '0;
    end else begin
      state <= state_nxt;
      // Counts consecutive ungranted REQ cycles; any other state clears it.
      if (state == S_REQ && !grant) wait_cnt <= wait_cnt + 1'b1;
      else                          wait_cnt <= '0;
      if (state == S_HEADER && xfer) tx_addr_b <= out_head >> HW;
      if (state == S_SIZE && xfer)         pay_cnt <= out_head[HW-1:0];
      else if (state == S_PAYLOAD && xfer) pay_cnt <= pay_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    request   = 1'b0;
    ack       = 1'b0;
    case (state)
      S_IDLE:    if (!out_empty) state_nxt = S_REQ;
      S_REQ: begin
        request = 1'b1;
        if (grant) state_nxt = S_HEADER;
        else if (REQ_TIMEOUT > 0 && wait_cnt == 32'(REQ_TIMEOUT - 1)) state_nxt = S_BACKOFF;
      end
      S_BACKOFF: state_nxt = S_REQ;
      S_HEADER:  if (xfer) state_nxt = S_SIZE;
      S_SIZE:    if (xfer) state_nxt = (out_head[HW-1:0] == '0) ? S_RELEASE : S_PAYLOAD;
      S_PAYLOAD: if (xfer && pay_cnt == HW'(1)) state_nxt = S_RELEASE;
      S_RELEASE: begin
        ack       = 1'b1;
        state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/noc_bus_bridge.md
NOC_BUS_BRIDGE -- requirements
Module: noc_bus_bridge

Interface
REQ-001 SHALL have parameter FLIT_W, default 32: flit width in bits; even, at least 8.
REQ-002 SHALL have parameter DEPTH, default 4: entries per FIFO; power of two, at least 2.
REQ-003 SHALL have parameter REQ_TIMEOUT, default 0: cycles in REQ without grant before backoff; 0 disables the timeout.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: router local port has a flit for the bus.
REQ-007 SHALL have port data_in, input, FLIT_W bits: flit from the router.
REQ-008 SHALL have port credit_o, output, 1 bit: bridge can accept a flit from the router.
REQ-009 SHALL have port tx, output, 1 bit: flit from the bus is valid toward the router.
REQ-010 SHALL have port data_out, output, FLIT_W bits: flit toward the router.
REQ-011 SHALL have port credit_i, input, 1 bit: router accepts the flit.
REQ-012 SHALL have port rx_b, input, 1 bit: bus flit is valid for this node.
REQ-013 SHALL have port data_in_b, input, FLIT_W bits: bus flit.
REQ-014 SHALL have port credit_o_b, output, 1 bit: bridge can accept a bus flit.
REQ-015 SHALL have port tx_b, output, 1 bit: bridge drives a valid flit on the bus.
REQ-016 SHALL have port data_out_b, output, FLIT_W bits: flit driven on the bus.
REQ-017 SHALL have port tx_addr_b, output, FLIT_W bits: destination of the current packet.
REQ-018 SHALL have port credit_i_b, input, 1 bit: bus target accepts the flit.
REQ-019 SHALL have port request, output, 1 bit: bus request to the arbiter.
REQ-020 SHALL have port grant, input, 1 bit: arbiter grant.
REQ-021 SHALL have port using_bus, output, 1 bit: bridge owns the bus.
REQ-022 SHALL have port ack, output, 1 bit: one-cycle pulse at packet release.

Function
REQ-023 SHALL buffer router-to-bus flits in an outbound FIFO (DEPTH): write when rx=1 and credit_o=1; rx while credit_o=0 ignored.
REQ-024 SHALL drive credit_o = outbound FIFO not full, combinationally; simultaneous push and pop SHALL leave the count unchanged; pointers wrap modulo DEPTH.
REQ-025 SHALL buffer bus-to-router flits in an inbound FIFO (DEPTH): write on rx_b and credit_o_b; credit_o_b = inbound not full.
REQ-026 SHALL drive tx = inbound not empty and data_out = inbound head; pop when tx and credit_i; a flit written to an empty FIFO SHALL appear on tx the next cycle.
REQ-027 SHALL sequence outbound packets (header, size, size payload flits) with the FSM IDLE, REQ, BACKOFF, HEADER, SIZE, PAYLOAD, RELEASE.
REQ-028 In IDLE: outbound not empty -> REQ.
REQ-029 In REQ: request=1; grant=1 -> HEADER. With REQ_TIMEOUT>0, REQ_TIMEOUT consecutive cycles without grant -> BACKOFF.
REQ-030 In BACKOFF: request=0 for exactly one cycle -> REQ, with the wait counter cleared.
REQ-031 grant SHALL be sampled only in REQ; a grant drop in HEADER through PAYLOAD SHALL be ignored.
REQ-032 In HEADER, SIZE and PAYLOAD: using_bus=1; tx_b = outbound not empty; data_out_b = outbound head, unmodified; a flit transfers and pops when tx_b and credit_i_b.
REQ-033 On the header transfer: register tx_addr_b = header >> (FLIT_W/2), with the upper half zero, and hold it until the next header; then -> SIZE.
REQ-034 On the size transfer: load a payload counter with the size flit, FLIT_W/2 LSBs; size 0 -> RELEASE, else -> PAYLOAD.
REQ-035 In PAYLOAD: decrement on each transfer; the transfer with counter=1 -> RELEASE.
REQ-036 In RELEASE: using_bus=0, request=0, ack=1 for one cycle -> IDLE; back-to-back packets SHALL re-request from IDLE.
REQ-037 request SHALL be 0 in all states except REQ.
REQ-038 tx_b SHALL be 0 outside HEADER, SIZE and PAYLOAD, and SHALL be 0 when outbound is empty (a starved packet stalls while holding the bus).

Reset
REQ-039 While reset=0 at a rising edge: FSM -> IDLE; both FIFOs empty; counters 0.
REQ-040 Reset values: tx_addr_b=0; request, using_bus, ack, tx, tx_b = 0; credit_o = credit_o_b = 1.
REQ-041 Reset mid-packet SHALL abandon the packet, with request and using_bus low after that edge.

Structure
REQ-042 The FSM state enum (bridge_state_t) and the FLIT_W and DEPTH defaults SHALL live in HeMPS_defaults; ports use regflit when FLIT_W=32.
REQ-043 The FIFO SHALL be one sub-module, bridge_fifo (parameters WIDTH and DEPTH), instantiated twice.

Verification
REQ-044 Router sends header 0x0102_0000, size 2, payloads 0xA, 0xB; grant after 3 cycles; credit_i_b=1 -> tx_addr_b=0x0000_0102; 4 tx_b flits on consecutive cycles; using_bus high for 4 cycles; one ack.
REQ-045 Header, then size 0 -> 2 bus flits, then RELEASE and ack; no PAYLOAD cycle.
REQ-046 REQ_TIMEOUT=4, grant held low -> request high 4 cycles, low 1, high again; grant arrives -> HEADER next cycle.
REQ-047 credit_i_b low 5 cycles mid-payload -> tx_b held, data_out_b stable, no pop; resumes when credit_i_b=1.
REQ-048 4 bus flits sent while credit_i=0 (DEPTH=4) -> credit_o_b=0 after the fourth; credit_i=1 -> flits delivered in order, credit_o_b returns to 1.
REQ-049 reset=0 during PAYLOAD -> next cycle request=0, using_bus=0, tx_b=0, credit_o=1; the next packet is handled normally.
